b2r_converter: RTL
==================

# b2r_converter

Block-to-row converter for the matrix-multiply output path. It accepts BLOCK_SIZE×BLOCK_SIZE result blocks from the Multi MAC array, streamed in the same column-group-major block order the weight path produces. It buffers a full ROW×COL matrix in banked on-chip RAM, then emits the matrix as row-major rows of COL elements for the downstream row buffer. It is the inverse of the weight row-to-block path.

## Interface
- WIDTH, 16, element width (fixed-point, not interpreted)
- FRAC_WIDTH, 8, carried for consistency, unused
- ROW, 256, matrix rows (multiple of BLOCK_SIZE)
- COL, 64, matrix columns (multiple of BLOCK_SIZE)
- BLOCK_SIZE, 2, block edge; also number of RAM banks
- BLK_WIDTH, WIDTH*BLOCK_SIZE*BLOCK_SIZE, input block width
- ROW_WIDTH, WIDTH*COL, output row width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin capturing one matrix; honoured only in IDLE
- in_valid  in  1  in_block valid
- in_ready  out  1  high throughout FILL
- in_block  in  BLK_WIDTH  one block, packing defined below
- out_valid  out  1  out_row valid
- out_ready  in  1  downstream accepts out_row
- out_row  out  ROW_WIDTH  one matrix row; column 0 in the MSBs
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last row handshake

## Operation
- Block order: the block row index br (0..ROW/B-1) increments fastest, then the block column index bc (0..COL/B-1). TOTAL_BLOCKS = (ROW/B)*(COL/B).
- Block packing: element (r,c) inside a block, with k = c*B + r, sits at in_block[BLK_WIDTH-1-k*WIDTH -: WIDTH] (column-major, MSB first).
  - For B=2 the MSB-first order is (0,0),(1,0),(0,1),(1,1).
- Destination: element (r,c) of block (br,bc) goes to matrix row br*B+r, column bc*B+c.
- Storage: B banks. Bank r holds matrix rows ≡ r mod B at address row/B, depth ROW/B, width ROW_WIDTH.
  - Each bank has a per-element write enable.
  - One accepted block writes B elements into each bank in the same cycle: address br, elements bc*B..bc*B+B-1.
- FSM:
  - IDLE: in_ready=0. Goes to FILL on start.
  - FILL: in_ready=1. Each in_valid&in_ready handshake writes one block and advances br/bc. Goes to DRAIN on the handshake of block TOTAL_BLOCKS-1.
  - DRAIN: reads rows 0..ROW-1 in order, from bank (row mod B) at address row/B, and presents them on out_row. After the handshake of row ROW-1: done=1 for one cycle and the FSM goes to IDLE.
- start outside IDLE is ignored. in_valid outside FILL is ignored and nothing is written.
- The RAM is not cleared. A second matrix overwrites every location before that location is read.

## Timing
- Reset values:
  - state=IDLE; in_ready=0, out_valid=0, busy=0, done=0.
  - out_row=0; br, bc and the row counter = 0.
- FILL accepts one block per cycle with no bubbles. The write lands in RAM on the handshake edge.
- RAM read is synchronous with 1-cycle latency. The first out_valid rises 2 cycles after DRAIN entry: one cycle for read issue, one for the output register.
- A 2-entry skid buffer sits behind the read pipe. With out_ready held high, one row is emitted per cycle with no bubbles, so the last row appears ROW+1 cycles after DRAIN entry.
- While out_valid=1 and out_ready=0, out_row is held stable. No read is issued that would overflow the skid buffer.
- The first DRAIN read may use the bank written on the final FILL edge. The write-before-read ordering is guaranteed by the one-cycle separation.
- done is asserted in the cycle after the final output handshake, with busy=0 in that same cycle.
- Reset asserted mid-FILL or mid-DRAIN: the next edge forces all reset values and drops any rows in flight.

## Structure
- Shared package holds the state encoding (IDLE, FILL, DRAIN) and the helpers TOTAL_BLOCKS and BANK_DEPTH = ROW/BLOCK_SIZE. These are shared with the weight-path converter.
- One sub-module, ram_1w1r_be: a single-port-write, single-port-read synchronous RAM with per-element write enable. It is instantiated BLOCK_SIZE times in a generate loop.
- The counters, FSM, read pipe and skid buffer stay in the top module.

## Test plan
Bench parameters: ROW=4, COL=4, B=2, WIDTH=16. Element value = row*16+col.
- Reset, then start, then 4 back-to-back blocks in order (0,0),(1,0),(0,1),(1,1), out_ready=1 -> rows 0..3 in consecutive cycles.
  - Row 0 = 0x0000,0x0001,0x0002,0x0003; row 3 = 0x0030..0x0033.
  - done pulses once, the cycle after row 3.
- Same stimulus with in_valid toggling 1/0 -> identical output. Blocks are written only on handshake cycles.
- out_ready low for 3 cycles while row 1 is presented -> out_row stays at 0x0010..0x0013. Rows 2 and 3 follow with none lost or duplicated.
- start asserted during FILL and in_valid asserted in IDLE -> no state change and no RAM write.
- rst_n low for one cycle mid-DRAIN, after row 1 -> next cycle out_valid=0, busy=0, state IDLE. A fresh matrix (element value + 0x100) then drains correctly.
- Default parameters (256×64), random data, blocks fed in scoreboard order -> all 256 rows match the reference model. The last row handshake occurs 257 cycles after DRAIN entry.

Source files
------------

// File: rtl/b2r_converter_pkg.sv
// Shared definitions for the block/row converters of the matrix-multiply datapath.
// Holds the converter state encoding and the geometry helpers used to size
// counters and RAM banks. Also used by the weight-path row-to-block converter.
package b2r_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of BxB blocks in a rows x cols matrix.
  function automatic int total_blocks(input int rows, input int cols, input int blk);
    return (rows / blk) * (cols / blk);
  endfunction

  // Rows held by each of the blk banks.
  function automatic int bank_depth(input int rows, input int blk);
    return rows / blk;
  endfunction

  // Index width for a counter over n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_1w1r_be.sv
// Purpose : one-write/one-read synchronous RAM with a write enable per element.
// Latency : read data registered, valid the cycle after re_i; write lands on the edge.
// Backpr. : none; the owner decides when to read and write.
// Ports   : clk_i; we_i[NE] per-element write enable, waddr_i, wdata_i;
//           re_i, raddr_i, rdata_o (holds its value while re_i is low).
//           Element e occupies data bits [e*DW +: DW].
module ram_1w1r_be #(
  parameter int DW    = 16,
  parameter int NE    = 64,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk_i,
  input  logic [NE-1:0]    we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DW*NE-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [DW*NE-1:0] rdata_o
);

  logic [DW*NE-1:0] mem_q [DEPTH];
  logic [DW*NE-1:0] rdata_q;

  // Contents are never cleared: every location is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < NE; e++) begin
      if (we_i[e]) begin
        mem_q[waddr_i][e*DW +: DW] <= wdata_i[e*DW +: DW];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/b2r_converter.sv
// Purpose : gathers BxB result blocks (column-group-major) into banked RAM, then
//           streams the whole ROWxCOL matrix out as row-major rows.
// Latency : first out_valid 2 cycles after the final block handshake, then 1 row/cycle.
// Backpr. : in_ready high for the whole fill; out_ready low holds out_row, and a
//           2-entry skid buffer with read credit keeps the read pipe from overflowing.
// Ports   : clk, rst_n (sync, active-low); start (IDLE only); in_valid/in_ready/in_block;
//           out_valid/out_ready/out_row (column 0 in the MSBs); busy; done (1-cycle pulse).
module b2r_converter
  import b2r_converter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROW        = 256,
  parameter int COL        = 64,
  parameter int BLOCK_SIZE = 2,
  parameter int BLK_WIDTH  = WIDTH * BLOCK_SIZE * BLOCK_SIZE,
  parameter int ROW_WIDTH  = WIDTH * COL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLK_WIDTH-1:0] in_block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_WIDTH-1:0] out_row,
  output logic                 busy,
  output logic                 done
);

  localparam int BANK_DEPTH = bank_depth(ROW, BLOCK_SIZE);
  localparam int BLK_COLS   = COL / BLOCK_SIZE;
  localparam int BR_W       = cnt_width(BANK_DEPTH);
  localparam int BC_W       = cnt_width(BLK_COLS);
  localparam int BK_W       = cnt_width(BLOCK_SIZE);
  localparam int RC_W       = $clog2(ROW + 1);

  localparam logic [BR_W-1:0] BR_LAST = BR_W'(BANK_DEPTH - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLK_COLS - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROW - 1);
  localparam logic [RC_W-1:0] RC_END  = RC_W'(ROW);

  // Elaboration-time sanity checks on the geometry.
  if ((ROW % BLOCK_SIZE) != 0 || (COL % BLOCK_SIZE) != 0) begin : g_bad_geom
    $error("ROW and COL must be multiples of BLOCK_SIZE");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH exceeds WIDTH");
  end

  // ---------------------------------------------------------------- state
  state_e            state_q, state_d;
  logic [BR_W-1:0]   br_q, br_d;          // block row of the next block to accept
  logic [BC_W-1:0]   bc_q, bc_d;          // block column of the next block to accept
  logic [RC_W-1:0]   rd_row_q, rd_row_d;  // rows issued to the RAM so far
  logic [RC_W-1:0]   out_cnt_q, out_cnt_d;// rows handed downstream so far
  logic              done_q, done_d;

  // Read pipe and skid buffer; head_q is the output register.
  logic              rd_vld_q;
  logic [BK_W-1:0]   rd_bank_q;
  logic [ROW_WIDTH-1:0] head_q, head_d;
  logic [ROW_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;

  // ---------------------------------------------------------------- RAM side
  logic [COL-1:0]       bank_we    [BLOCK_SIZE];
  logic [ROW_WIDTH-1:0] bank_wdata [BLOCK_SIZE];
  logic [ROW_WIDTH-1:0] bank_rdata [BLOCK_SIZE];
  logic [BLOCK_SIZE-1:0] bank_re;
  logic [BK_W-1:0]      rd_bank;
  logic [BR_W-1:0]      rd_addr;
  logic [ROW_WIDTH-1:0] rd_data;

  logic in_hs, last_blk, pop, last_row, issue;

  assign in_hs    = (state_q == ST_FILL) && in_valid;
  assign last_blk = (br_q == BR_LAST) && (bc_q == BC_LAST);
  assign pop      = (cnt_q != 2'd0) && out_ready;
  assign last_row = (out_cnt_q == RC_LAST);

  // A read is allowed only if, after this cycle's pop, the rows already buffered
  // plus the one in the RAM stage leave room for it in the two skid entries.
  always_comb begin
    issue = 1'b0;
    if (state_q == ST_DRAIN && rd_row_q != RC_END) begin
      issue = (int'(cnt_q) + int'(rd_vld_q) - int'(pop)) < 2;
    end
  end

  assign rd_bank = BK_W'(int'(rd_row_q) % BLOCK_SIZE);
  assign rd_addr = BR_W'(int'(rd_row_q) / BLOCK_SIZE);
  assign rd_data = bank_rdata[rd_bank_q];

  // Block element (r,c) goes to bank r, column bc*B+c; column j is RAM element COL-1-j
  // so that column 0 ends up in the MSBs of the stored row.
  always_comb begin
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      bank_we[r]    = '0;
      bank_wdata[r] = '0;
      bank_re[r]    = issue && (rd_bank == BK_W'(r));
      if (in_hs) begin
        for (int c = 0; c < BLOCK_SIZE; c++) begin
          bank_we[r][COL-1-(int'(bc_q)*BLOCK_SIZE + c)] = 1'b1;
          bank_wdata[r][ROW_WIDTH-1-(int'(bc_q)*BLOCK_SIZE + c)*WIDTH -: WIDTH] =
            in_block[BLK_WIDTH-1-(c*BLOCK_SIZE + r)*WIDTH -: WIDTH];
        end
      end
    end
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_bank
    ram_1w1r_be #(
      .DW    (WIDTH),
      .NE    (COL),
      .DEPTH (BANK_DEPTH),
      .AW    (BR_W)
    ) u_ram (
      .clk_i   (clk),
      .we_i    (bank_we[g]),
      .waddr_i (br_q),
      .wdata_i (bank_wdata[g]),
      .re_i    (bank_re[g]),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[g])
    );
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d   = state_q;
    br_d      = br_q;
    bc_d      = bc_q;
    rd_row_d  = rd_row_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          br_d    = '0;
          bc_d    = '0;
        end
      end
      ST_FILL: begin
        if (in_hs) begin
          // br runs fastest, then bc; both wrap to zero after the final block.
          if (br_q == BR_LAST) begin
            br_d = '0;
            bc_d = (bc_q == BC_LAST) ? '0 : bc_q + 1'b1;
          end else begin
            br_d = br_q + 1'b1;
          end
          if (last_blk) begin
            state_d   = ST_DRAIN;
            rd_row_d  = '0;
            out_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (issue) begin
          rd_row_d = rd_row_q + 1'b1;
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (last_row) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- skid buffer
  // Push comes from the RAM stage, pop from the downstream handshake. The credit
  // rule above guarantees no push arrives while both entries are full.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
      end else if (rd_vld_q) begin
        head_d = rd_data;
      end
    end else if (rd_vld_q) begin
      if (cnt_q == 2'd0) begin
        head_d = rd_data;
      end else begin
        tail_d = rd_data;
      end
    end
    cnt_d = 2'(cnt_q + {1'b0, rd_vld_q} - {1'b0, pop});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      br_q      <= '0;
      bc_q      <= '0;
      rd_row_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_bank_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      br_q      <= br_d;
      bc_q      <= bc_d;
      rd_row_q  <= rd_row_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      rd_vld_q  <= issue;
      if (issue) begin
        rd_bank_q <= rd_bank;
      end
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (cnt_q != 2'd0);
  assign out_row   = head_q;
  assign done      = done_q;

endmodule
